// File: rtl/dram_cycle_sched.sv
// DRAM cycle scheduler: arbitrates video fetch, RAS-only refresh and CPU accesses
// onto one 16-bit DRAM array and drives registered, glitch-free strobes.
module dram_cycle_sched #(
    parameter int REF_PERIOD = 64,
    parameter int T_PRE      = 1,
    parameter int REF_MAX    = 3
) (
    input  logic        pin_clk,
    input  logic        pin_r,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_be,
    input  logic [13:0] cpu_addr,
    output logic        cpu_rply,
    input  logic        vid_req,
    input  logic [13:0] vid_addr,
    output logic        vid_load,
    output logic        vid_ovr,
    output logic [6:0]  pin_ma,
    output logic        pin_ras_n,
    output logic [1:0]  pin_cas_n,
    output logic        pin_we_n,
    output logic        lat_le
);

    localparam int TW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
    localparam int PW = (T_PRE > 1) ? $clog2(T_PRE) : 1;
    localparam int CW = $clog2(REF_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_ROW, S_COL, S_DATA, S_PRE, S_RHOLD} state_t;
    typedef enum logic [1:0] {K_VID, K_CPU, K_REF} kind_t;

    state_t        state_reg, state_next;
    kind_t         kind_reg, kind_next;
    logic [13:0]   addr_reg, addr_next;
    logic          wr_reg, wr_next;
    logic [1:0]    be_reg, be_next;
    logic [PW-1:0] pre_reg, pre_next;
    logic          vid_pend_reg, vid_pend_next;
    logic [13:0]   vid_addr_reg;
    logic          vid_ovr_reg;
    logic [6:0]    ref_row_reg, ref_row_next;
    logic [TW-1:0] ref_tmr_reg;
    logic [CW-1:0] ref_pend_reg, ref_pend_next;
    logic          grant_vid, grant_ref, tmr_wrap, vid_any, cpu_ok;
    logic [6:0]    ma_reg, ma_next;
    logic          ras_n_reg, ras_n_next, we_n_reg, we_n_next;
    logic [1:0]    cas_n_reg, cas_n_next, cas_wr_n;
    logic          lat_le_reg, lat_le_next, vid_load_reg, vid_load_next, rply_reg;

    // A pulse arriving in IDLE competes directly, so it can win against a same-cycle CPU request.
    assign vid_any  = vid_req | vid_pend_reg;
    assign cpu_ok   = cpu_req & ~rply_reg;
    assign tmr_wrap = (ref_tmr_reg == TW'(REF_PERIOD - 1));

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cas
            assign cas_wr_n[gi] = ~be_next[gi];
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        kind_next    = kind_reg;
        addr_next    = addr_reg;
        wr_next      = wr_reg;
        be_next      = be_reg;
        pre_next     = pre_reg;
        ref_row_next = ref_row_reg;
        grant_vid    = 1'b0;
        grant_ref    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (vid_any) begin
                    state_next = S_ROW;
                    kind_next  = K_VID;
                    addr_next  = vid_req ? vid_addr : vid_addr_reg;
                    wr_next    = 1'b0;
                    grant_vid  = 1'b1;
                end else if (ref_pend_reg == CW'(REF_MAX)) begin
                    state_next = S_ROW;
                    kind_next  = K_REF;
                    grant_ref  = 1'b1;
                end else if (cpu_ok) begin
                    state_next = S_ROW;
                    kind_next  = K_CPU;
                    addr_next  = cpu_addr;
                    wr_next    = cpu_we;
                    be_next    = cpu_be;
                end else if (ref_pend_reg != '0) begin
                    state_next = S_ROW;
                    kind_next  = K_REF;
                    grant_ref  = 1'b1;
                end
            end
            S_ROW:   state_next = (kind_reg == K_REF) ? S_RHOLD : S_COL;
            S_COL:   state_next = S_DATA;
            S_DATA: begin
                state_next = S_PRE;
                pre_next   = '0;
            end
            S_RHOLD: begin
                state_next   = S_PRE;
                pre_next     = '0;
                ref_row_next = ref_row_reg + 7'd1;
            end
            S_PRE: begin
                if (pre_reg == PW'(T_PRE - 1)) state_next = S_IDLE;
                else                           pre_next   = pre_reg + PW'(1);
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ref_pend_next = ref_pend_reg;
        if (tmr_wrap && !grant_ref) begin
            if (ref_pend_reg != CW'(REF_MAX)) ref_pend_next = ref_pend_reg + CW'(1);
        end else if (!tmr_wrap && grant_ref) begin
            ref_pend_next = ref_pend_reg - CW'(1);
        end
        vid_pend_next = grant_vid ? 1'b0 : (vid_req | vid_pend_reg);
    end

    // Strobes are decoded from the next state so every pin comes straight from a flop.
    always_comb begin
        ma_next       = ma_reg;
        ras_n_next    = 1'b1;
        cas_n_next    = 2'b11;
        we_n_next     = 1'b1;
        lat_le_next   = 1'b0;
        vid_load_next = 1'b0;
        case (state_next)
            S_ROW: begin
                ras_n_next = 1'b0;
                ma_next    = (kind_next == K_REF) ? ref_row_reg : addr_next[6:0];
            end
            S_RHOLD: ras_n_next = 1'b0;
            S_COL, S_DATA: begin
                ras_n_next = 1'b0;
                ma_next    = addr_next[13:7];
                if (kind_next == K_CPU && wr_next) begin
                    cas_n_next = cas_wr_n;
                    we_n_next  = 1'b0;
                end else begin
                    cas_n_next = 2'b00;
                end
                lat_le_next   = (kind_next == K_CPU) && !wr_next;
                vid_load_next = (state_next == S_DATA) && (kind_next == K_VID);
            end
            default: ;
        endcase
    end

    always_ff @(posedge pin_clk) begin
        if (pin_r) begin
            state_reg    <= S_IDLE;
            kind_reg     <= K_VID;
            addr_reg     <= '0;
            wr_reg       <= 1'b0;
            be_reg       <= '0;
            pre_reg      <= '0;
            vid_pend_reg <= 1'b0;
            vid_addr_reg <= '0;
            vid_ovr_reg  <= 1'b0;
            ref_row_reg  <= '0;
            ref_tmr_reg  <= '0;
            ref_pend_reg <= '0;
            ma_reg       <= '0;
            ras_n_reg    <= 1'b1;
            cas_n_reg    <= 2'b11;
            we_n_reg     <= 1'b1;
            lat_le_reg   <= 1'b0;
            vid_load_reg <= 1'b0;
            rply_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            kind_reg     <= kind_next;
            addr_reg     <= addr_next;
            wr_reg       <= wr_next;
            be_reg       <= be_next;
            pre_reg      <= pre_next;
            vid_pend_reg <= vid_pend_next;
            if (vid_req) vid_addr_reg <= vid_addr;
            vid_ovr_reg  <= vid_ovr_reg | (vid_req & vid_pend_reg);
            ref_row_reg  <= ref_row_next;
            ref_tmr_reg  <= tmr_wrap ? '0 : ref_tmr_reg + TW'(1);
            ref_pend_reg <= ref_pend_next;
            ma_reg       <= ma_next;
            ras_n_reg    <= ras_n_next;
            cas_n_reg    <= cas_n_next;
            we_n_reg     <= we_n_next;
            lat_le_reg   <= lat_le_next;
            vid_load_reg <= vid_load_next;
            // Reply rises on entry to PRE and then follows the request handshake.
            rply_reg     <= ((state_reg == S_DATA) && (kind_reg == K_CPU)) | (rply_reg & cpu_req);
        end
    end

    assign cpu_rply  = rply_reg;
    assign vid_load  = vid_load_reg;
    assign vid_ovr   = vid_ovr_reg;
    assign pin_ma    = ma_reg;
    assign pin_ras_n = ras_n_reg;
    assign pin_cas_n = cas_n_reg;
    assign pin_we_n  = we_n_reg;
    assign lat_le    = lat_le_reg;

endmodule

// File: tb/tb_dram_cycle_sched.sv
// Bench for dram_cycle_sched: a bus-cycle queue model predicts every pin per clock,
// driven by directed scenarios followed by a long randomized run.
module tb_dram_cycle_sched;
    localparam int REF_PERIOD = 64;
    localparam int T_PRE      = 1;
    localparam int REF_MAX    = 3;

    logic        pin_clk = 1'b0;
    logic        pin_r, cpu_req, cpu_we, vid_req;
    logic [1:0]  cpu_be;
    logic [13:0] cpu_addr, vid_addr;
    logic        cpu_rply, vid_load, vid_ovr, pin_ras_n, pin_we_n, lat_le;
    logic [6:0]  pin_ma;
    logic [1:0]  pin_cas_n;

    always #5 pin_clk = ~pin_clk;

    dram_cycle_sched #(.REF_PERIOD(REF_PERIOD), .T_PRE(T_PRE), .REF_MAX(REF_MAX)) dut (
        .pin_clk(pin_clk), .pin_r(pin_r),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_rply(cpu_rply),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_load(vid_load), .vid_ovr(vid_ovr),
        .pin_ma(pin_ma), .pin_ras_n(pin_ras_n), .pin_cas_n(pin_cas_n), .pin_we_n(pin_we_n),
        .lat_le(lat_le)
    );

    // One expected bus clock: what the pins must show during that cycle.
    typedef struct {
        bit         ma_chk;
        logic [6:0] ma;
        logic       ras_n;
        logic [1:0] cas_n;
        logic       we_n;
        logic       lat_le;
        logic       vid_load;
        bit         rply_set;
    } cyc_t;

    cyc_t        q[$];
    cyc_t        cur;
    bit          m_vid_pend, m_ovr, m_rply;
    logic [13:0] m_vid_addr;
    int          m_ref_row, m_tmr, m_pend;
    int          n_tests = 0, n_fail = 0;
    bit          prev_ras = 1'b1, row_pend = 1'b0;
    logic [6:0]  row_ma;
    bit          obs_ref[$];
    logic [6:0]  obs_ma[$];

    function automatic cyc_t mk(bit mc, logic [6:0] ma, logic ras, logic [1:0] cas, logic we,
                                logic le, logic vl, bit rs);
        cyc_t c;
        c.ma_chk = mc; c.ma = ma; c.ras_n = ras; c.cas_n = cas; c.we_n = we;
        c.lat_le = le; c.vid_load = vl; c.rply_set = rs;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        n_tests++;
        n_fail++;
        $error("FAIL %s: observed timeout expected completion", tag);
    endtask

    task automatic push_tail(bit is_cpu);
        for (int i = 0; i < T_PRE; i++)
            q.push_back(mk(0, 7'd0, 1, 2'b11, 1, 0, 0, is_cpu && (i == 0)));
        q.push_back(mk(0, 7'd0, 1, 2'b11, 1, 0, 0, 0));
    endtask

    task automatic push_access(bit is_cpu, bit wr, logic [1:0] be, logic [13:0] a);
        logic [1:0] cas;
        logic       we, le;
        cas = (is_cpu && wr) ? ~be : 2'b00;
        we  = !(is_cpu && wr);
        le  = is_cpu && !wr;
        q.push_back(mk(1, a[6:0], 0, 2'b11, 1, 0, 0, 0));
        q.push_back(mk(1, a[13:7], 0, cas, we, le, 0, 0));
        q.push_back(mk(1, a[13:7], 0, cas, we, le, !is_cpu, 0));
        push_tail(is_cpu);
    endtask

    task automatic push_ref();
        q.push_back(mk(1, 7'(m_ref_row), 0, 2'b11, 1, 0, 0, 0));
        q.push_back(mk(0, 7'd0, 0, 2'b11, 1, 0, 0, 0));
        push_tail(0);
        m_ref_row = (m_ref_row + 1) % 128;
    endtask

    // Applies the rules for the coming clock edge using the inputs currently driven.
    task automatic model_edge();
        bit vgrant, dec, inc;
        vgrant = 0; dec = 0;
        if (pin_r) begin
            q.delete();
            cur = mk(1, 7'd0, 1, 2'b11, 1, 0, 0, 0);
            m_vid_pend = 0; m_ovr = 0; m_rply = 0; m_vid_addr = '0;
            m_ref_row = 0; m_tmr = 0; m_pend = 0;
            return;
        end
        if (q.size() == 0) begin
            if (vid_req || m_vid_pend) begin
                push_access(0, 0, 2'b00, vid_req ? vid_addr : m_vid_addr);
                vgrant = 1;
            end else if (m_pend == REF_MAX) begin
                push_ref(); dec = 1;
            end else if (cpu_req && !m_rply) begin
                push_access(1, cpu_we, cpu_be, cpu_addr);
            end else if (m_pend > 0) begin
                push_ref(); dec = 1;
            end
        end
        if (vid_req && m_vid_pend) m_ovr = 1;
        if (vgrant) m_vid_pend = 0;
        else if (vid_req) m_vid_pend = 1;
        if (vid_req) m_vid_addr = vid_addr;
        inc = (m_tmr == REF_PERIOD - 1);
        m_tmr = inc ? 0 : m_tmr + 1;
        m_pend = m_pend + int'(inc) - int'(dec);
        if (m_pend > REF_MAX) m_pend = REF_MAX;
        cur = (q.size() != 0) ? q.pop_front() : mk(0, 7'd0, 1, 2'b11, 1, 0, 0, 0);
        m_rply = cur.rply_set ? 1'b1 : (m_rply && cpu_req);
    endtask

    task automatic cycle();
        model_edge();
        @(posedge pin_clk);
        #1;
        chk("ras_n", pin_ras_n, cur.ras_n);
        chk("cas_n", pin_cas_n, cur.cas_n);
        chk("we_n", pin_we_n, cur.we_n);
        chk("lat_le", lat_le, cur.lat_le);
        chk("vid_load", vid_load, cur.vid_load);
        chk("cpu_rply", cpu_rply, m_rply);
        chk("vid_ovr", vid_ovr, m_ovr);
        if (cur.ma_chk) chk("ma", pin_ma, cur.ma);
        if (row_pend) begin
            obs_ref.push_back(pin_cas_n == 2'b11 && pin_ras_n == 1'b0);
            obs_ma.push_back(row_ma);
            row_pend = 0;
        end
        if (prev_ras && !pin_ras_n) begin
            row_pend = 1;
            row_ma   = pin_ma;
        end
        prev_ras = pin_ras_n;
    endtask

    task automatic wait_quiet();
        for (int i = 0; i < 40 && q.size() != 0; i++) cycle();
        if (q.size() != 0) fail_now("wait_quiet");
    endtask

    task automatic finish_cpu();
        int n;
        n = 0;
        while (!m_rply && n < 60) begin cycle(); n++; end
        if (!m_rply) fail_now("cpu_rply_wait");
        cpu_req = 0;
        cycle();
        chk("rply_drop", cpu_rply, 1'b0);
    endtask

    initial begin
        int k, gap, cwait;
        logic [13:0] a_v, a_c;
        pin_r = 1; cpu_req = 0; cpu_we = 0; cpu_be = 2'b00; cpu_addr = '0;
        vid_req = 0; vid_addr = '0;
        cycle(); cycle();
        chk("rst_ma", pin_ma, 7'd0);
        chk("rst_ras_n", pin_ras_n, 1'b1);
        chk("rst_cas_n", pin_cas_n, 2'b11);
        pin_r = 0;
        cycle();

        // CPU read of 14'h1F85 on an idle array
        wait_quiet();
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'h1F85;
        cycle();
        chk("rd_row_ma", pin_ma, 7'h05);
        chk("rd_row_ras", pin_ras_n, 1'b0);
        cycle();
        chk("rd_col_ma", pin_ma, 7'h3F);
        chk("rd_col_cas", pin_cas_n, 2'b00);
        chk("rd_col_le", lat_le, 1'b1);
        cycle(); cycle();
        chk("rd_rply_c3", cpu_rply, 1'b1);
        cycle(); cycle();
        chk("rd_rply_hold", cpu_rply, 1'b1);
        cpu_req = 0;
        cycle();
        chk("rd_rply_fall", cpu_rply, 1'b0);

        // High-byte-only write
        wait_quiet();
        cpu_req = 1; cpu_we = 1; cpu_be = 2'b10; cpu_addr = 14'h2A5C;
        cycle(); cycle();
        chk("bw_col_cas", pin_cas_n, 2'b01);
        chk("bw_col_we", pin_we_n, 1'b0);
        cycle();
        chk("bw_data_cas", pin_cas_n, 2'b01);
        finish_cpu();

        // Video and CPU requested in the same cycle: video wins
        wait_quiet();
        a_v = 14'h1234; a_c = 14'h0ABC;
        vid_req = 1; vid_addr = a_v;
        cpu_req = 1; cpu_we = 0; cpu_addr = a_c;
        cycle();
        chk("vc_vid_row", pin_ma, a_v[6:0]);
        vid_req = 0;
        cycle(); cycle();
        chk("vc_vid_load", vid_load, 1'b1);
        for (int i = 0; i < T_PRE + 1; i++) cycle();
        cycle();
        chk("vc_cpu_ras", pin_ras_n, 1'b0);
        chk("vc_cpu_row", pin_ma, a_c[6:0]);
        finish_cpu();

        // Two video pulses while a CPU cycle owns the array
        wait_quiet();
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'h3001;
        cycle();
        vid_req = 1; vid_addr = 14'h0111;
        cycle();
        vid_addr = 14'h2222;
        cycle();
        vid_req = 0;
        chk("ovr_set", vid_ovr, 1'b1);
        finish_cpu();
        for (int i = 0; i < 12; i++) cycle();
        chk("ovr_sticky", vid_ovr, 1'b1);

        // Reset during COL of a CPU write
        wait_quiet();
        cpu_req = 1; cpu_we = 1; cpu_be = 2'b11; cpu_addr = 14'h0F0F;
        cycle(); cycle();
        pin_r = 1; cpu_req = 0;
        cycle();
        chk("mrst_ras", pin_ras_n, 1'b1);
        chk("mrst_cas", pin_cas_n, 2'b11);
        chk("mrst_we", pin_we_n, 1'b1);
        chk("mrst_rply", cpu_rply, 1'b0);
        chk("mrst_ovr", vid_ovr, 1'b0);
        pin_r = 0;

        // Video keeps the array busy long enough for refresh to saturate
        obs_ref.delete(); obs_ma.delete();
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'h1555;
        for (int i = 0; i < 200; i++) begin
            vid_req = (i % 5 == 0); vid_addr = 14'(i * 37);
            cycle();
        end
        vid_req = 0;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (m_rply && cpu_req) cpu_req = 0;
        end
        k = 0;
        while (k < obs_ref.size() && !obs_ref[k]) k++;
        if (obs_ref.size() < k + 4) fail_now("sat_sequence");
        else begin
            chk("sat_ref0_row", obs_ma[k], 7'd0);
            chk("sat_cpu_next", obs_ref[k + 1], 1'b0);
            chk("sat_ref1", obs_ref[k + 2], 1'b1);
            chk("sat_ref1_row", obs_ma[k + 2], 7'd1);
            chk("sat_ref2", obs_ref[k + 3], 1'b1);
            chk("sat_ref2_row", obs_ma[k + 3], 7'd2);
        end

        // Randomized traffic; long enough for the refresh row to wrap past 127
        gap = 0; cwait = 0;
        for (int i = 0; i < 10000; i++) begin
            gap++;
            if ((gap >= 4 + T_PRE && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0) begin
                vid_req = 1; vid_addr = 14'($urandom); gap = 0;
            end else begin
                vid_req = 0;
            end
            if (!cpu_req) begin
                if (!m_rply && $urandom_range(0, 3) == 0) begin
                    cpu_req = 1; cpu_we = 1'($urandom); cpu_be = 2'($urandom);
                    cpu_addr = 14'($urandom); cwait = 0;
                end
            end else begin
                cwait++;
                if (m_rply) begin
                    if ($urandom_range(0, 1) == 0) cpu_req = 0;
                end else if (cwait > 80) begin
                    fail_now("cpu_latency");
                    cpu_req = 0;
                end
            end
            cycle();
        end
        vid_req = 0; cpu_req = 0;
        cycle(); cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
